retire_trace_stream: RTL and testbench

//  Hardware retire-trace capture for the pipelined RV32I core. Samples one retire record per cycle from the
//  M stage (pc, inst, rd, result, mem address/data), filters by mode, buffers in a parametrised FIFO and

---
 rtl/trace_pkg.sv | 29 ++
 rtl/trace_fifo.sv | 47 ++++
 rtl/retire_trace_stream.sv | 104 ++++++++++
 tb/tb_retire_trace_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared encodings, packet layout and record type for the retire-trace stream.
package trace_pkg;
    localparam logic [1:0] KIND_NONE  = 2'd0;
    localparam logic [1:0] KIND_REG   = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;
    localparam logic [1:0] KIND_LOAD  = 2'd3;
    localparam logic [7:0] HDR_BYTE   = 8'hA5;
    localparam int REC_BYTES = 16;
    localparam int OFS_B1    = 1;
    localparam int OFS_PC    = 2;
    localparam int OFS_INST  = 4;
    localparam int OFS_DATA  = 8;
    localparam int OFS_ADDR  = 12;
    // Field order makes {record, header} the packet with B0 in the low byte.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] inst;
        logic [15:0] pc;
        logic        ovf;
        logic [1:0]  kind;
        logic [4:0]  rd;
    } trace_rec_t;
    localparam int REC_W = $bits(trace_rec_t);
    typedef enum logic {IDLE, SEND} state_t;
    function automatic logic [REC_BYTES*8-1:0] to_packet(input trace_rec_t r);
        return {r, HDR_BYTE};
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with occupancy count; a push while full is accepted only alongside a pop.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr, rd;
    always_comb begin
        wr       = push && (!full || pop);
        rd       = pop && !empty;
        wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr) - CW'(rd);
    end
    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];
    always_ff @(posedge CLK) begin
        if (wr) mem_q[wr_ptr_q] <= wdata;
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/retire_trace_stream.sv
// retire_trace_stream: filters M-stage retire records, queues them and streams 16-byte packets.
// Define TRACE_BACKPRESSURE_EN to raise stall_req near full instead of relying on drops alone.
module retire_trace_stream
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PC_W  = 13,
    parameter int XLEN  = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [1:0]      mode,
    input  logic            ret_valid,
    input  logic [PC_W-1:0] ret_pc,
    input  logic [XLEN-1:0] ret_inst,
    input  logic [4:0]      ret_rd,
    input  logic            ret_reg_write,
    input  logic [2:0]      ret_load,
    input  logic [1:0]      ret_store,
    input  logic [XLEN-1:0] ret_data,
    input  logic [XLEN-1:0] ret_addr,
    output logic            out_valid,
    output logic [7:0]      out_data,
    input  logic            out_ready,
    output logic            stall_req,
    output logic [15:0]     drop_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    trace_rec_t             cap_q, cap_d, head;
    logic                   cap_valid_q, cap_valid_d;
    logic                   ovf_pending_q, ovf_pending_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    state_t                 state_q, state_d;
    logic [3:0]             idx_q, idx_d;
    logic [1:0]             kind;
    logic                   pass, full, empty, pop, drop;
    logic [CW-1:0]          count;
    logic [REC_BYTES*8-1:0] pkt;
    always_comb begin
        kind = ret_store != 2'b00 ? KIND_STORE :
               ret_load != 3'b000 ? KIND_LOAD :
               (ret_reg_write && ret_rd != 5'd0) ? KIND_REG : KIND_NONE;
        pass = mode == 2'b00 || (mode == 2'b01 && kind != KIND_NONE) || (mode == 2'b10 && kind[1]);
        pop  = state_q == SEND && out_ready && idx_q == 4'd15;
        drop = cap_valid_q && full && !pop;
        ovf_pending_d = drop ? 1'b1 : cap_valid_q ? 1'b0 : ovf_pending_q;
        drop_cnt_d    = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        cap_valid_d   = ret_valid && pass;
        // The flag pending when this record reaches the FIFO next cycle is exactly ovf_pending_d.
        cap_d.ovf  = ovf_pending_d;
        cap_d.kind = kind;
        cap_d.rd   = ret_rd;
        cap_d.pc   = 16'({1'b1, ret_pc, 2'b00});
        cap_d.inst = ret_inst;
        cap_d.data = ret_store == 2'b01 ? {24'd0, ret_data[7:0]} :
                     ret_store == 2'b10 ? {16'd0, ret_data[15:0]} : ret_data;
        cap_d.addr = kind[1] ? ret_addr : '0;
        state_d = state_q == IDLE ? (empty ? IDLE : SEND) : (pop && count == CW'(1)) ? IDLE : SEND;
        idx_d   = (state_q == SEND && out_ready) ? idx_q + 4'd1 : idx_q;
    end
    trace_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (cap_valid_q),
        .pop   (pop),
        .wdata (cap_q),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    assign pkt       = to_packet(head);
    assign out_valid = state_q == SEND;
    assign out_data  = out_valid ? pkt[{idx_q, 3'b000} +: 8] : 8'd0;
    assign drop_cnt  = drop_cnt_q;
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cap_valid_q   <= 1'b0;
            cap_q         <= '0;
            ovf_pending_q <= 1'b0;
            drop_cnt_q    <= '0;
            state_q       <= IDLE;
            idx_q         <= '0;
        end else begin
            cap_valid_q   <= cap_valid_d;
            cap_q         <= cap_d;
            ovf_pending_q <= ovf_pending_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
        end
    end
`ifdef TRACE_BACKPRESSURE_EN
    logic stall_q, stall_d;
    assign stall_d   = count >= CW'(DEPTH - 2);
    assign stall_req = stall_q;
    always_ff @(posedge CLK) begin
        if (!RST_N) stall_q <= 1'b0;
        else        stall_q <= stall_d;
    end
`else
    assign stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_retire_trace_stream.sv
// tb_retire_trace_stream: directed scenarios with hand-computed packets for retire_trace_stream.
module tb_retire_trace_stream;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        ret_valid = 1'b0;
    logic [12:0] ret_pc = '0;
    logic [31:0] ret_inst = '0;
    logic [4:0]  ret_rd = '0;
    logic        ret_reg_write = 1'b0;
    logic [2:0]  ret_load = '0;
    logic [1:0]  ret_store = '0;
    logic [31:0] ret_data = '0;
    logic [31:0] ret_addr = '0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        stall_req;
    logic [15:0] drop_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    retire_trace_stream dut (
        .CLK(CLK), .RST_N(RST_N), .mode(mode), .ret_valid(ret_valid), .ret_pc(ret_pc),
        .ret_inst(ret_inst), .ret_rd(ret_rd), .ret_reg_write(ret_reg_write), .ret_load(ret_load),
        .ret_store(ret_store), .ret_data(ret_data), .ret_addr(ret_addr), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .stall_req(stall_req), .drop_cnt(drop_cnt)
    );

    // Presents one retire for a single cycle; called and returns at a negedge.
    task automatic drive_ret(input logic [12:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                             input logic rw, input logic [2:0] ld, input logic [1:0] st,
                             input logic [31:0] data, input logic [31:0] addr);
        ret_valid = 1'b1; ret_pc = pc; ret_inst = inst; ret_rd = rd; ret_reg_write = rw;
        ret_load = ld; ret_store = st; ret_data = data; ret_addr = addr;
        @(negedge CLK);
        ret_valid = 1'b0;
    endtask

    task automatic recv_pkt(input bit toggle, output logic [127:0] p, output int nb);
        p = '0;
        nb = 0;
        for (int c = 0; c < 200 && nb < 16; c++) begin
            out_ready = toggle ? !out_ready : 1'b1;
            if (out_valid && out_ready) begin
                p[nb*8 +: 8] = out_data;
                nb++;
            end
            @(negedge CLK);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL reset_stall_req: got %b want 0", stall_req); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt: got %h want 0000", drop_cnt); end
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single_addi;
        logic [127:0] p;
        int nb;
        drive_ret(13'h0010, 32'h02A00293, 5'd5, 1'b1, 3'b000, 2'b00, 32'h0000002A, 32'hFFFFFFFF);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_t0: got %b want 0", out_valid); end
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL latency_t1: got %b want 0", out_valid); end
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_bad++; $display("FAIL latency_t2: got %b/%h want 1/a5", out_valid, out_data); end
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin n_bad++; $display("FAIL hold_stable: got %b/%h want 1/a5", out_valid, out_data); end
        recv_pkt(1'b0, p, nb);
        n_cmp++; if (nb !== 16 || p !== {32'h0, 32'h0000002A, 32'h02A00293, 16'h8040, 8'h25, 8'hA5}) begin
            n_bad++; $display("FAIL addi_packet: got %0d bytes %h want 16 bytes %h", nb, p, {32'h0, 32'h0000002A, 32'h02A00293, 16'h8040, 8'h25, 8'hA5});
        end
    endtask

    task automatic test_store_byte;
        logic [127:0] p;
        int nb;
        drive_ret(13'h0011, 32'h00B50023, 5'd0, 1'b0, 3'b000, 2'b01, 32'h12345678, 32'h0000F95C);
        recv_pkt(1'b0, p, nb);
        n_cmp++; if (nb !== 16 || p !== {32'h0000F95C, 32'h00000078, 32'h00B50023, 16'h8044, 8'h40, 8'hA5}) begin
            n_bad++; $display("FAIL sb_packet: got %0d bytes %h want 16 bytes %h", nb, p, {32'h0000F95C, 32'h00000078, 32'h00B50023, 16'h8044, 8'h40, 8'hA5});
        end
    endtask

    task automatic test_overflow;
        logic [127:0] p;
        int nb;
        int bad_kept;
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++)
            drive_ret(13'(i), 32'h00000013, 5'(i + 1), 1'b1, 3'b000, 2'b00, 32'(i), 32'h0);
        repeat (2) @(negedge CLK);
        n_cmp++; if (drop_cnt !== 16'd4) begin n_bad++; $display("FAIL drop_cnt: got %0d want 4", drop_cnt); end
        n_cmp++; if (stall_req !== 1'b0) begin n_bad++; $display("FAIL stall_default: got %b want 0", stall_req); end
        bad_kept = 0;
        for (int i = 0; i < 16; i++) begin
            recv_pkt(1'b0, p, nb);
            if (nb !== 16 || p[15] !== 1'b0 || p[95:64] !== 32'(i) || p[7:0] !== 8'hA5) bad_kept++;
        end
        n_cmp++; if (bad_kept !== 0) begin n_bad++; $display("FAIL kept_16_packets: got %0d bad packets want 0", bad_kept); end
        repeat (3) @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL no_17th_queued: got %b want 0", out_valid); end
        drive_ret(13'h40, 32'h00000013, 5'd1, 1'b1, 3'b000, 2'b00, 32'd100, 32'h0);
        drive_ret(13'h41, 32'h00000013, 5'd2, 1'b1, 3'b000, 2'b00, 32'd101, 32'h0);
        recv_pkt(1'b0, p, nb);
        n_cmp++; if (nb !== 16 || p[15:8] !== 8'hA1 || p[95:64] !== 32'd100) begin n_bad++; $display("FAIL ovf_pkt17: got b1 %h data %h want a1 %h", p[15:8], p[95:64], 32'd100); end
        recv_pkt(1'b0, p, nb);
        n_cmp++; if (nb !== 16 || p[15:8] !== 8'h22 || p[95:64] !== 32'd101) begin n_bad++; $display("FAIL ovf_pkt18: got b1 %h data %h want 22 %h", p[15:8], p[95:64], 32'd101); end
    endtask

    task automatic test_mode_filter;
        logic [127:0] p;
        int nb;
        mode = 2'b01;
        drive_ret(13'h20, 32'h00208463, 5'd0, 1'b0, 3'b000, 2'b00, 32'h11, 32'h22);
        drive_ret(13'h21, 32'h00000013, 5'd0, 1'b1, 3'b000, 2'b00, 32'h0, 32'h0);
        drive_ret(13'h22, 32'h00A00493, 5'd9, 1'b1, 3'b000, 2'b00, 32'h0A, 32'h99);
        mode = 2'b11;
        drive_ret(13'h23, 32'h00012203, 5'd4, 1'b1, 3'b011, 2'b00, 32'h1, 32'h4);
        mode = 2'b10;
        drive_ret(13'h24, 32'h00300193, 5'd3, 1'b1, 3'b000, 2'b00, 32'h3, 32'h0);
        drive_ret(13'h25, 32'h00012203, 5'd4, 1'b1, 3'b011, 2'b00, 32'hCAFEF00D, 32'h00001000);
        drive_ret(13'h26, 32'h00112223, 5'd0, 1'b0, 3'b000, 2'b11, 32'hDEADBEEF, 32'h00002004);
        drive_ret(13'h27, 32'h00208463, 5'd0, 1'b0, 3'b000, 2'b00, 32'h0, 32'h0);
        mode = 2'b00;
        recv_pkt(1'b0, p, nb);
        n_cmp++; if (nb !== 16 || p !== {32'h0, 32'h0000000A, 32'h00A00493, 16'h8088, 8'h29, 8'hA5}) begin
            n_bad++; $display("FAIL mode01_addi: got %h want %h", p, {32'h0, 32'h0000000A, 32'h00A00493, 16'h8088, 8'h29, 8'hA5});
        end
        recv_pkt(1'b0, p, nb);
        n_cmp++; if (nb !== 16 || p !== {32'h00001000, 32'hCAFEF00D, 32'h00012203, 16'h8094, 8'h64, 8'hA5}) begin
            n_bad++; $display("FAIL mode10_lw: got %h want %h", p, {32'h00001000, 32'hCAFEF00D, 32'h00012203, 16'h8094, 8'h64, 8'hA5});
        end
        recv_pkt(1'b0, p, nb);
        n_cmp++; if (nb !== 16 || p !== {32'h00002004, 32'hDEADBEEF, 32'h00112223, 16'h8098, 8'h40, 8'hA5}) begin
            n_bad++; $display("FAIL mode10_sw: got %h want %h", p, {32'h00002004, 32'hDEADBEEF, 32'h00112223, 16'h8098, 8'h40, 8'hA5});
        end
        repeat (3) @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mode_no_extra: got %b want 0", out_valid); end
    endtask

    task automatic test_ready_toggle;
        logic [127:0] p;
        int nb;
        int total;
        drive_ret(13'h30, 32'h00A59023, 5'd0, 1'b0, 3'b000, 2'b10, 32'hAABBCCDD, 32'h00000010);
        drive_ret(13'h31, 32'h0105C383, 5'd7, 1'b1, 3'b100, 2'b00, 32'h000000FF, 32'h00000011);
        drive_ret(13'h32, 32'h00700F93, 5'd31, 1'b1, 3'b000, 2'b00, 32'h00000007, 32'h00000055);
        recv_pkt(1'b1, p, nb);
        total = nb;
        n_cmp++; if (nb !== 16 || p !== {32'h00000010, 32'h0000CCDD, 32'h00A59023, 16'h80C0, 8'h40, 8'hA5}) begin
            n_bad++; $display("FAIL toggle_sh: got %h want %h", p, {32'h00000010, 32'h0000CCDD, 32'h00A59023, 16'h80C0, 8'h40, 8'hA5});
        end
        recv_pkt(1'b1, p, nb);
        total += nb;
        n_cmp++; if (nb !== 16 || p !== {32'h00000011, 32'h000000FF, 32'h0105C383, 16'h80C4, 8'h67, 8'hA5}) begin
            n_bad++; $display("FAIL toggle_lbu: got %h want %h", p, {32'h00000011, 32'h000000FF, 32'h0105C383, 16'h80C4, 8'h67, 8'hA5});
        end
        recv_pkt(1'b1, p, nb);
        total += nb;
        n_cmp++; if (nb !== 16 || p !== {32'h0, 32'h00000007, 32'h00700F93, 16'h80C8, 8'h3F, 8'hA5}) begin
            n_bad++; $display("FAIL toggle_addi: got %h want %h", p, {32'h0, 32'h00000007, 32'h00700F93, 16'h80C8, 8'h3F, 8'hA5});
        end
        n_cmp++; if (total !== 48) begin n_bad++; $display("FAIL toggle_bytes: got %0d want 48", total); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] b [64];
        int run;
        for (int i = 1; i <= 3; i++)
            drive_ret(13'(i), 32'h00000013, 5'(i), 1'b1, 3'b000, 2'b00, 32'(i), 32'h0);
        repeat (3) @(negedge CLK);
        run = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && run < 64) begin
                b[run] = out_data;
                run++;
            end else if (run > 0) break;
            @(negedge CLK);
        end
        out_ready = 1'b0;
        n_cmp++; if (run !== 48) begin n_bad++; $display("FAIL b2b_run: got %0d contiguous bytes want 48", run); end
        n_cmp++; if (b[0] !== 8'hA5 || b[16] !== 8'hA5 || b[32] !== 8'hA5) begin n_bad++; $display("FAIL b2b_headers: got %h %h %h want a5 a5 a5", b[0], b[16], b[32]); end
        n_cmp++; if (b[24] !== 8'h02 || b[40] !== 8'h03) begin n_bad++; $display("FAIL b2b_data: got %h %h want 02 03", b[24], b[40]); end
    endtask

    task automatic test_reset_mid_packet;
        int nb;
        int seen;
        drive_ret(13'h50, 32'h00100093, 5'd1, 1'b1, 3'b000, 2'b00, 32'h1, 32'h0);
        drive_ret(13'h51, 32'h00200113, 5'd2, 1'b1, 3'b000, 2'b00, 32'h2, 32'h0);
        nb = 0;
        for (int c = 0; c < 100 && nb < 7; c++) begin
            out_ready = 1'b1;
            if (out_valid) nb++;
            @(negedge CLK);
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || drop_cnt !== 16'd4) begin n_bad++; $display("FAIL pre_reset_state: got %b/%0d want 1/4", out_valid, drop_cnt); end
        RST_N = 1'b0;
        @(negedge CLK);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midpkt_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL midpkt_drop_cnt: got %0d want 0", drop_cnt); end
        RST_N = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge CLK);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL residual_bytes: got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset;
        test_single_addi;
        test_store_byte;
        test_overflow;
        test_mode_filter;
        test_ready_toggle;
        test_back_to_back;
        test_reset_mid_packet;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
